m_ext_issue: RTL and testbench



---
 rtl/m_ext_issue.sv | 160 ++++++++++++++++
 tb/tb_m_ext_issue.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_ext_issue.sv
// M-extension issue controller: sequences MUL-family ops into the Multiplier.
// Optional result reuse of the last completed op: M_EXT_RESULT_REUSE_EN.
module m_ext_issue #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [4:0]      req_rd,
    output logic [2:0]      mul_sel,
    output logic [XLEN-1:0] mul_a,
    output logic [XLEN-1:0] mul_b,
    input  logic            mul_ready,
    input  logic [XLEN-1:0] mul_res,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            err_illegal,
    output logic            err_timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic             acc;
    logic             launch;
    logic             hit;
    logic             at_lim;

    assign req_ready = (state == IDLE);
    assign stall     = (state != IDLE);
    assign acc       = req_valid & req_ready;
    assign launch    = acc & ~req_funct3[2] & (req_rd != 5'd0);
    assign at_lim    = (cnt == CNT_LIM);

`ifdef M_EXT_RESULT_REUSE_EN
    logic            c_valid;
    logic [2:0]      c_f3;
    logic [2:0]      op_f3;
    logic [XLEN-1:0] c_rs1;
    logic [XLEN-1:0] c_rs2;
    logic [XLEN-1:0] c_res;

    assign hit = c_valid & (c_f3 == req_funct3) &
                 (c_rs1 == req_rs1) & (c_rs2 == req_rs2);

    // Only ready-terminated results are cached; a timeout drops the entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_valid <= 1'b0;
            c_f3    <= 3'd0;
            op_f3   <= 3'd0;
            c_rs1   <= '0;
            c_rs2   <= '0;
            c_res   <= '0;
        end else begin
            if (state == IDLE && acc)
                op_f3 <= req_funct3;
            if (state == WAIT) begin
                if (mul_ready) begin
                    c_valid <= 1'b1;
                    c_f3    <= op_f3;
                    c_rs1   <= mul_a;
                    c_rs2   <= mul_b;
                    c_res   <= mul_res;
                end else if (at_lim) begin
                    c_valid <= 1'b0;
                end
            end
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (launch) state_n = hit ? RESP : ISSUE;
            ISSUE: state_n = WAIT;
            WAIT:  if (mul_ready || at_lim) state_n = RESP;
            RESP:  if (wb_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_sel     <= 3'd0;
            mul_a       <= '0;
            mul_b       <= '0;
            wb_valid    <= 1'b0;
            wb_rd       <= 5'd0;
            wb_data     <= '0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
            cnt         <= '0;
        end else begin
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (acc && req_funct3[2]) begin
                        err_illegal <= 1'b1;
                    end else if (launch) begin
                        wb_rd <= req_rd;
                        if (hit) begin
                            wb_valid <= 1'b1;
`ifdef M_EXT_RESULT_REUSE_EN
                            wb_data  <= c_res;
`endif
                        end else begin
                            mul_sel <= req_funct3 + 3'd1;
                            mul_a   <= req_rs1;
                            mul_b   <= req_rs2;
                        end
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    // Ready on the limit cycle still counts as a result.
                    if (mul_ready) begin
                        wb_data  <= mul_res;
                        mul_sel  <= 3'd0;
                        wb_valid <= 1'b1;
                    end else if (at_lim) begin
                        wb_data     <= '0;
                        mul_sel     <= 3'd0;
                        wb_valid    <= 1'b1;
                        err_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: if (wb_ready) wb_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_m_ext_issue.sv
// Self-checking bench for m_ext_issue: directed plan steps plus random ops
// against a behavioural multiply model and a last-result cache model.
module tb_m_ext_issue;

    localparam int TMO = 64;

    logic        clk = 0;
    logic        rst = 1;
    logic        req_valid = 0;
    logic        req_ready;
    logic [2:0]  req_funct3 = 0;
    logic [31:0] req_rs1 = 0;
    logic [31:0] req_rs2 = 0;
    logic [4:0]  req_rd = 0;
    logic [2:0]  mul_sel;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_ready = 0;
    logic [31:0] mul_res = 0;
    logic        wb_valid;
    logic        wb_ready = 0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic        err_illegal;
    logic        err_timeout;

    int errors = 0;
    int checks = 0;

    int mlat   = -1;
    bit mstale = 0;
    int mcnt   = 0;

    bit          c_valid = 0;
    logic [2:0]  c_f3;
    logic [31:0] c_a;
    logic [31:0] c_b;
    logic [31:0] last_wb;

    m_ext_issue dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_rd(req_rd),
        .mul_sel(mul_sel), .mul_a(mul_a), .mul_b(mul_b),
        .mul_ready(mul_ready), .mul_res(mul_res),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall),
        .err_illegal(err_illegal), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mulref(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Multiplier model: ready on WAIT cycle mlat, optional bogus ready in ISSUE.
    always @(negedge clk) begin
        if (mul_sel == 3'd0) mcnt = 0;
        else mcnt = mcnt + 1;
        mul_ready = 0;
        mul_res   = $urandom;
        if (mul_sel != 3'd0) begin
            if (mstale && mcnt == 1) begin
                mul_ready = 1;
            end else if (mlat > 0 && mcnt == mlat + 1) begin
                mul_ready = 1;
                mul_res   = mulref(mul_sel - 3'd1, mul_a, mul_b);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input int lat, input bit stale, input int hold);
        logic [31:0] exp;
        int n;
        bit hit;
        bit tmo;
        mlat   = lat;
        mstale = stale;
        req_valid  = 1;
        req_funct3 = f3;
        req_rs1    = a;
        req_rs2    = b;
        req_rd     = rd;
        check("req_ready_idle", 32'(req_ready), 1);
        tick();
        req_valid = 0;
        if (f3[2]) begin
            check("illegal_pulse", 32'(err_illegal), 1);
            check("illegal_stall", 32'(stall), 0);
            check("illegal_wbv", 32'(wb_valid), 0);
            tick();
            check("illegal_once", 32'(err_illegal), 0);
            check("illegal_nowb", 32'(wb_valid), 0);
            return;
        end
        if (rd == 5'd0) begin
            check("rd0_sel", 32'(mul_sel), 0);
            check("rd0_stall", 32'(stall), 0);
            tick();
            check("rd0_nowb", 32'(wb_valid), 0);
            check("rd0_sel2", 32'(mul_sel), 0);
            return;
        end
`ifdef M_EXT_RESULT_REUSE_EN
        hit = c_valid && c_f3 == f3 && c_a == a && c_b == b;
`else
        hit = 0;
`endif
        tmo = (lat <= 0 || lat > TMO);
        exp = tmo ? 32'd0 : mulref(f3, a, b);
        if (hit) begin
            check("hit_wbv", 32'(wb_valid), 1);
            check("hit_sel", 32'(mul_sel), 0);
        end else begin
            check("issue_stall", 32'(stall), 1);
            check("issue_sel", 32'(mul_sel), 32'(f3) + 1);
            check("issue_a", mul_a, a);
            check("issue_b", mul_b, b);
            check("issue_wbv", 32'(wb_valid), 0);
            n = 0;
            while (!wb_valid && n < 200) begin
                tick();
                n++;
                if (!wb_valid) begin
                    check("wait_sel", 32'(mul_sel), 32'(f3) + 1);
                    check("wait_stall", 32'(stall), 1);
                    check("wait_tmo", 32'(err_timeout), 0);
                end
            end
            check("latency", 32'(n), tmo ? 32'(TMO + 1) : 32'(lat + 1));
            check("tmo_pulse", 32'(err_timeout), 32'(tmo));
            check("resp_sel", 32'(mul_sel), 0);
        end
        check("wb_rd", 32'(wb_rd), 32'(rd));
        check("wb_data", wb_data, exp);
        check("resp_stall", 32'(stall), 1);
        check("resp_ready", 32'(req_ready), 0);
        last_wb = wb_data;
        for (int i = 0; i < hold; i++) begin
            req_valid  = 1;
            req_funct3 = 3'd0;
            req_rd     = 5'd9;
            tick();
            check("hold_wbv", 32'(wb_valid), 1);
            check("hold_rd", 32'(wb_rd), 32'(rd));
            check("hold_data", wb_data, exp);
            check("hold_reqrdy", 32'(req_ready), 0);
            check("hold_tmo", 32'(err_timeout), 0);
            check("hold_sel", 32'(mul_sel), 0);
        end
        wb_ready = 1;
        tick();
        wb_ready  = 0;
        req_valid = 0;
        check("xfer_wbv", 32'(wb_valid), 0);
        check("xfer_reqrdy", 32'(req_ready), 1);
        check("xfer_tmo", 32'(err_timeout), 0);
        check("xfer_sel", 32'(mul_sel), 0);
        if (!hit) check("idle_a_kept", mul_a, a);
        if (tmo) begin
            c_valid = 0;
        end else begin
            c_valid = 1;
            c_f3 = f3;
            c_a  = a;
            c_b  = b;
        end
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [4:0]  rd;

        tick();
        tick();
        rst = 0;
        check("rst_sel", 32'(mul_sel), 0);
        check("rst_a", mul_a, 0);
        check("rst_b", mul_b, 0);
        check("rst_wbv", 32'(wb_valid), 0);
        check("rst_wbrd", 32'(wb_rd), 0);
        check("rst_wbdata", wb_data, 0);
        check("rst_ill", 32'(err_illegal), 0);
        check("rst_tmo", 32'(err_timeout), 0);
        check("rst_ready", 32'(req_ready), 1);
        check("rst_stall", 32'(stall), 0);

        // Reset in the middle of WAIT.
        mlat = -1;
        mstale = 0;
        req_valid = 1;
        req_funct3 = 3'd0;
        req_rs1 = 32'd7;
        req_rs2 = 32'd9;
        req_rd = 5'd3;
        tick();
        req_valid = 0;
        tick();
        tick();
        tick();
        check("mid_stall", 32'(stall), 1);
        rst = 1;
        tick();
        tick();
        rst = 0;
        check("mrst_wbv", 32'(wb_valid), 0);
        check("mrst_sel", 32'(mul_sel), 0);
        check("mrst_ready", 32'(req_ready), 1);
        check("mrst_stall", 32'(stall), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mrst_nowb", 32'(wb_valid), 0);
        end
        c_valid = 0;

        do_op(3'd0, -32'sd250000, 32'sd280000, 5'd5, 4, 0, 0);
        check("t2_lit", last_wb, 32'hB3AC_C400);
        do_op(3'd1, -32'sd250000, 32'sd280000, 5'd6, 2, 0, 0);
        check("t3_mulh", last_wb, 32'hFFFF_FFEF);
        do_op(3'd2, 32'hFFFF_FFFC, 32'd2, 5'd7, 1, 0, 0);
        check("t3_mulhsu", last_wb, 32'hFFFF_FFFF);
        do_op(3'd3, 32'hFFFF_FFFC, 32'd2, 5'd8, 3, 0, 0);
        check("t3_mulhu", last_wb, 32'h0000_0001);

        do_op(3'd0, 32'd12345, 32'd678, 5'd10, 2, 0, 5);
        do_op(3'd4, 32'd1, 32'd2, 5'd11, 1, 0, 0);
        do_op(3'd7, 32'd1, 32'd2, 5'd11, 1, 0, 0);
        do_op(3'd0, 32'd3, 32'd4, 5'd0, 1, 0, 0);

        do_op(3'd0, 32'd100, 32'd200, 5'd12, -1, 0, 0);
        check("t6_tmo_data", last_wb, 32'd0);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd13, TMO, 0, 0);
        do_op(3'd3, 32'hDEAD_0001, 32'h1234_5678, 5'd14, 2, 1, 1);

        do_op(3'd0, -32'sd250000, 32'sd280000, 5'd5, 4, 0, 0);
        do_op(3'd0, -32'sd250000, 32'sd280000, 5'd5, 4, 0, 0);
        check("t6_reuse", last_wb, 32'hB3AC_C400);

        for (int k = 0; k < 30; k++) begin
            if (k > 0 && $urandom_range(3) == 0) begin
                f3 = c_f3;
                a  = c_a;
                b  = c_b;
            end else begin
                f3 = 3'($urandom_range(7));
                a  = ($urandom_range(3) == 0) ? 32'h8000_0000 : $urandom;
                b  = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
            end
            rd = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
            do_op(f3, a, b, rd, $urandom_range(6, 1),
                  $urandom_range(1) == 1, $urandom_range(3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
